wb: RTL and testbench
=====================

# wb

Write-back stage of the five-stage pipelined CPU, directly downstream of the memory-access stage. Consumes the 119-bit MEM->WB bus and commits the instruction. Writes the general register file, owns the HI/LO registers and the CP0 STATUS/CAUSE/EPC registers, and executes syscall/break/eret. Raises a redirect (exception bus) and a pipeline-cancel toward fetch and the earlier stages.

## Interface
Parameters:
- EXC_ENTER_ADDR, 32'h0000_0000, exception entry PC for syscall/break

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset; synchronous, active-high
- WB_valid  in  1  WB stage holds a valid instruction this cycle
- MEM_WB_bus_r  in  119  registered MEM->WB bus, MSB first: rf_wen[118], rf_wdest[117:113], mem_result[112:81], lo_result[80:49], hi_write[48], lo_write[47], mfhi[46], mflo[45], mtc0[44], mfc0[43], cp0r_addr[42:35] ({rd,sel}), syscall[34], break[33], eret[32], pc[31:0]
- rf_wen  out  1  register-file write enable
- rf_wdest  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- WB_over  out  1  WB finished this cycle
- WB_wdest  out  5  destination for hazard check; 0 when not valid
- exc_bus  out  33  {exc_valid, exc_pc[31:0]} redirect to fetch
- cancel  out  1  flush IF/ID/EXE/MEM contents
- WB_pc  out  32  PC of the WB instruction, for display
- HI_data, LO_data  out  32 each  current HI/LO contents, for display

## Operation
- Stage is always single-cycle: WB_over = WB_valid. No internal stall.
- The CP0 read mux decodes cp0r_addr:
  - {5'd12,3'd0} = STATUS
  - {5'd13,3'd0} = CAUSE
  - {5'd14,3'd0} = EPC
  - Any other address reads 0; an mtc0 to any other address is ignored.
- rf_wdata priority: mfhi -> HI; mflo -> LO; mfc0 -> the selected CP0 register; otherwise mem_result.
- rf_wen = WB_valid & rf_wen_bus & ~syscall & ~break & ~rst. rf_wdest passes through. WB_wdest = rf_wdest & {5{WB_valid}}.
- HI/LO updates, only when WB_valid:
  - hi_write: HI <= mem_result.
  - lo_write: LO <= lo_result.
  - Both may be set together (mult/multu); both update in the same edge.
- STATUS: only bit 1 (EXL) and bit 0 (IE) are implemented. All other bits read 0.
  - mtc0 writes bits [1:0] from mem_result.
  - syscall/break sets EXL.
  - eret clears EXL.
- CAUSE: only ExcCode [6:2] is implemented; all other bits read 0.
  - syscall writes 5'h08; break writes 5'h09.
  - CAUSE is not mtc0-writable.
- EPC:
  - mtc0 writes the full 32 bits from mem_result.
  - syscall/break writes pc.
- Redirect:
  - syscall or break (with WB_valid): exc_valid = 1, exc_pc = EXC_ENTER_ADDR.
  - eret: exc_valid = 1, exc_pc = current EPC register value.
  - cancel = exc_valid. exc_valid is forced 0 while rst is high.
- A syscall/break instruction performs no register-file, HI/LO or mtc0 write.

## Timing
- Reset (rst high at a clock edge):
  - HI, LO, STATUS, CAUSE and EPC clear to 0.
  - rf_wen, exc_bus[32] and cancel read 0 for the whole cycle in which rst is high, regardless of WB_valid.
  - WB_over and WB_wdest still follow WB_valid.
- Reset mid-operation: the instruction in WB during the reset cycle is discarded. No state write and no redirect occur.
- rf_*, exc_bus and cancel are combinational from WB_valid and the bus, valid within the same cycle. The register file commits at the next rising edge.
- HI/LO/CP0 writes take effect at the rising edge that ends the WB cycle. The next instruction in WB reads the new value; there is no same-cycle bypass.
  - Example: mult then mfhi back-to-back returns the new HI.
  - Example: mtc0 EPC then eret in the next cycle redirects to the new EPC.
- exc_valid and cancel are one-cycle pulses per triggering instruction. The register updates caused by that instruction commit at the same edge.
- WB_valid low: no state changes; all write enables and exc_valid are 0.

## Test plan
- Reset with WB_valid=1 and syscall=1 -> exc_valid=0, rf_wen=0. After reset: HI=LO=STATUS=CAUSE=EPC=0.
- mult result (hi_write=lo_write=1, mem_result=32'h0000_0001, lo_result=32'hFFFF_FFFE), then mfhi to r3, then mflo to r4 -> rf_wdata 32'h1 then 32'hFFFF_FFFE, rf_wdest 3 then 4.
- syscall at pc=32'h0000_0040 -> exc_bus=33'h1_0000_0000 and cancel=1 for one cycle. Afterwards EPC=32'h40, CAUSE=32'h20, STATUS[1]=1, rf_wen=0.
- mtc0 to EPC with 32'h0000_1234, then eret next cycle -> exc_pc=32'h1234, exc_valid=1. STATUS[1] is 0 afterwards.
- mfc0 from {5'd9,3'd0} (unimplemented) with rf_wen=1 -> rf_wdata=0. mtc0 to CAUSE with 32'hFFFF_FFFF -> CAUSE unchanged.
- WB_valid=0 with rf_wen=1, hi_write=1 and break=1 on the bus -> rf_wen=0, exc_valid=0, WB_wdest=0, HI unchanged.

Source files
------------

// File: rtl/wb.sv
// Write-back stage: commits results to the register file, owns HI/LO and the
// CP0 STATUS/CAUSE/EPC registers, and raises syscall/break/eret redirects.
module wb #(
  parameter logic [31:0] EXC_ENTER_ADDR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         WB_valid,
  input  logic [118:0] MEM_WB_bus_r,
  output logic         rf_wen,
  output logic [4:0]   rf_wdest,
  output logic [31:0]  rf_wdata,
  output logic         WB_over,
  output logic [4:0]   WB_wdest,
  output logic [32:0]  exc_bus,
  output logic         cancel,
  output logic [31:0]  WB_pc,
  output logic [31:0]  HI_data,
  output logic [31:0]  LO_data
);

  localparam logic [7:0] CP0_STATUS = {5'd12, 3'd0};
  localparam logic [7:0] CP0_CAUSE  = {5'd13, 3'd0};
  localparam logic [7:0] CP0_EPC    = {5'd14, 3'd0};

  logic        bus_rf_wen;
  logic [4:0]  bus_rf_wdest;
  logic [31:0] mem_result;
  logic [31:0] lo_result;
  logic        hi_write;
  logic        lo_write;
  logic        mfhi;
  logic        mflo;
  logic        mtc0;
  logic        mfc0;
  logic [7:0]  cp0r_addr;
  logic        syscall;
  logic        brk;
  logic        eret;
  logic [31:0] pc;

  assign {bus_rf_wen, bus_rf_wdest, mem_result, lo_result, hi_write, lo_write,
          mfhi, mflo, mtc0, mfc0, cp0r_addr, syscall, brk, eret, pc} = MEM_WB_bus_r;

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [1:0]  status_q, status_d;
  logic [4:0]  cause_q, cause_d;
  logic [31:0] epc_q, epc_d;

  logic        commit_s;
  logic        is_exc_s;
  logic        wr_en_s;
  logic        exc_valid_s;
  logic [31:0] exc_pc_s;
  logic [31:0] cp0_rdata_s;

  // Commit qualifiers: reset discards the WB instruction; syscall/break suppress writes.
  always_comb begin
    commit_s    = WB_valid & ~rst;
    is_exc_s    = syscall | brk;
    wr_en_s     = commit_s & ~is_exc_s;
    exc_valid_s = commit_s & (is_exc_s | eret);
    exc_pc_s    = is_exc_s ? EXC_ENTER_ADDR : epc_q;
  end

  // CP0 read mux; unimplemented registers and bits read as zero.
  always_comb begin
    case (cp0r_addr)
      CP0_STATUS: cp0_rdata_s = {30'd0, status_q};
      CP0_CAUSE:  cp0_rdata_s = {25'd0, cause_q, 2'd0};
      CP0_EPC:    cp0_rdata_s = epc_q;
      default:    cp0_rdata_s = 32'd0;
    endcase
  end

  // Register-file write port and redirect outputs.
  always_comb begin
    rf_wen   = wr_en_s & bus_rf_wen;
    rf_wdest = bus_rf_wdest;
    if (mfhi) begin
      rf_wdata = hi_q;
    end else if (mflo) begin
      rf_wdata = lo_q;
    end else if (mfc0) begin
      rf_wdata = cp0_rdata_s;
    end else begin
      rf_wdata = mem_result;
    end
    WB_over  = WB_valid;
    WB_wdest = bus_rf_wdest & {5{WB_valid}};
    exc_bus  = {exc_valid_s, exc_pc_s};
    cancel   = exc_valid_s;
    WB_pc    = pc;
    HI_data  = hi_q;
    LO_data  = lo_q;
  end

  // Next-state for HI/LO and CP0; an eret alongside an mtc0 STATUS still clears EXL.
  always_comb begin
    hi_d = (wr_en_s && hi_write) ? mem_result : hi_q;
    lo_d = (wr_en_s && lo_write) ? lo_result  : lo_q;
    if (commit_s && is_exc_s) begin
      status_d = {1'b1, status_q[0]};
    end else if (wr_en_s && eret) begin
      status_d = {1'b0, (mtc0 && cp0r_addr == CP0_STATUS) ? mem_result[0] : status_q[0]};
    end else if (wr_en_s && mtc0 && cp0r_addr == CP0_STATUS) begin
      status_d = mem_result[1:0];
    end else begin
      status_d = status_q;
    end
    if (commit_s && is_exc_s) begin
      cause_d = syscall ? 5'h08 : 5'h09;
      epc_d   = pc;
    end else if (wr_en_s && mtc0 && cp0r_addr == CP0_EPC) begin
      cause_d = cause_q;
      epc_d   = mem_result;
    end else begin
      cause_d = cause_q;
      epc_d   = epc_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      status_q <= 2'd0;
      cause_q  <= 5'd0;
      epc_q    <= 32'd0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

endmodule

// File: tb/tb_wb.sv
// Randomized bench for the write-back stage, checked every cycle against an
// instruction-level model of HI/LO and CP0, plus directed literal checks.
module tb_wb;
  localparam logic [31:0] EXC_ADDR = 32'h0000_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic         WB_valid;
  logic [118:0] MEM_WB_bus_r;
  logic         rf_wen;
  logic [4:0]   rf_wdest;
  logic [31:0]  rf_wdata;
  logic         WB_over;
  logic [4:0]   WB_wdest;
  logic [32:0]  exc_bus;
  logic         cancel;
  logic [31:0]  WB_pc;
  logic [31:0]  HI_data;
  logic [31:0]  LO_data;

  // bus fields driven by stimulus
  logic        b_wen, b_hiw, b_low, b_mfhi, b_mflo, b_mtc0, b_mfc0, b_sys, b_brk, b_eret;
  logic [4:0]  b_dest;
  logic [31:0] b_mem, b_lo, b_pc;
  logic [7:0]  b_addr;

  assign MEM_WB_bus_r = {b_wen, b_dest, b_mem, b_lo, b_hiw, b_low, b_mfhi, b_mflo,
                         b_mtc0, b_mfc0, b_addr, b_sys, b_brk, b_eret, b_pc};

  wb #(.EXC_ENTER_ADDR(EXC_ADDR)) dut (
    .clk(clk), .rst(rst), .WB_valid(WB_valid), .MEM_WB_bus_r(MEM_WB_bus_r),
    .rf_wen(rf_wen), .rf_wdest(rf_wdest), .rf_wdata(rf_wdata), .WB_over(WB_over),
    .WB_wdest(WB_wdest), .exc_bus(exc_bus), .cancel(cancel), .WB_pc(WB_pc),
    .HI_data(HI_data), .LO_data(LO_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // architectural model: full 32-bit register values as software sees them
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_status = 32'd0, m_cause = 32'd0, m_epc = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cp0_read(input logic [7:0] a);
    if (a == 8'd96)       return m_status;
    else if (a == 8'd104) return m_cause;
    else if (a == 8'd112) return m_epc;
    else                  return 32'd0;
  endfunction

  task automatic compare_all();
    logic live, exc, e_exc;
    logic [31:0] e_data;
    live  = WB_valid && !rst;
    exc   = b_sys || b_brk;
    e_exc = live && (exc || b_eret);
    if (b_mfhi)      e_data = m_hi;
    else if (b_mflo) e_data = m_lo;
    else if (b_mfc0) e_data = cp0_read(b_addr);
    else             e_data = b_mem;
    chk("rf_wen", {63'd0, rf_wen}, {63'd0, live && b_wen && !exc});
    chk("rf_wdest", {59'd0, rf_wdest}, {59'd0, b_dest});
    chk("rf_wdata", {32'd0, rf_wdata}, {32'd0, e_data});
    chk("WB_over", {63'd0, WB_over}, {63'd0, WB_valid});
    chk("WB_wdest", {59'd0, WB_wdest}, {59'd0, WB_valid ? b_dest : 5'd0});
    chk("exc_valid", {63'd0, exc_bus[32]}, {63'd0, e_exc});
    chk("cancel", {63'd0, cancel}, {63'd0, e_exc});
    if (e_exc) chk("exc_pc", {32'd0, exc_bus[31:0]}, {32'd0, exc ? EXC_ADDR : m_epc});
    chk("WB_pc", {32'd0, WB_pc}, {32'd0, b_pc});
    chk("HI_data", {32'd0, HI_data}, {32'd0, m_hi});
    chk("LO_data", {32'd0, LO_data}, {32'd0, LO_data === LO_data ? m_lo : 32'd0});
  endtask

  task automatic update_model();
    if (rst) begin
      m_hi = 32'd0; m_lo = 32'd0; m_status = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
    end else if (WB_valid) begin
      if (b_sys || b_brk) begin
        m_epc    = b_pc;
        m_cause  = b_sys ? 32'd8 * 32'd4 : 32'd9 * 32'd4;
        m_status = m_status | 32'd2;
      end else begin
        if (b_hiw) m_hi = b_mem;
        if (b_low) m_lo = b_lo;
        if (b_mtc0 && b_addr == 8'd96)  m_status = b_mem & 32'd3;
        if (b_mtc0 && b_addr == 8'd112) m_epc = b_mem;
        if (b_eret) m_status = m_status & ~32'd2;
      end
    end
  endtask

  task automatic clear_bus();
    rst = 1'b0; WB_valid = 1'b0;
    {b_wen, b_hiw, b_low, b_mfhi, b_mflo, b_mtc0, b_mfc0, b_sys, b_brk, b_eret} = 10'd0;
    b_dest = 5'd0; b_mem = 32'd0; b_lo = 32'd0; b_pc = 32'd0; b_addr = 8'd0;
  endtask

  task automatic settle();
    @(negedge clk);
    compare_all();
  endtask

  task automatic advance();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic rd_cp0(input logic [7:0] a);
    clear_bus(); WB_valid = 1'b1; b_mfc0 = 1'b1; b_wen = 1'b1; b_dest = 5'd7; b_addr = a;
  endtask

  initial begin
    // reset while a syscall sits in WB: no write, no redirect
    clear_bus(); rst = 1'b1; WB_valid = 1'b1; b_sys = 1'b1; b_wen = 1'b1; b_pc = 32'h10;
    @(negedge clk);
    chk("rst_rf_wen", {63'd0, rf_wen}, 64'd0);
    chk("rst_exc_valid", {63'd0, exc_bus[32]}, 64'd0);
    chk("rst_cancel", {63'd0, cancel}, 64'd0);
    chk("rst_WB_over", {63'd0, WB_over}, 64'd1);
    advance();
    settle(); advance();
    clear_bus();
    settle();
    chk("rst_HI", {32'd0, HI_data}, 64'd0);
    chk("rst_LO", {32'd0, LO_data}, 64'd0);
    advance();
    rd_cp0({5'd12, 3'd0}); settle(); chk("rst_STATUS", {32'd0, rf_wdata}, 64'd0); advance();
    rd_cp0({5'd13, 3'd0}); settle(); chk("rst_CAUSE", {32'd0, rf_wdata}, 64'd0); advance();
    rd_cp0({5'd14, 3'd0}); settle(); chk("rst_EPC", {32'd0, rf_wdata}, 64'd0); advance();

    // mult, then mfhi r3, mflo r4
    clear_bus(); WB_valid = 1'b1; b_hiw = 1'b1; b_low = 1'b1;
    b_mem = 32'h0000_0001; b_lo = 32'hFFFF_FFFE; settle(); advance();
    clear_bus(); WB_valid = 1'b1; b_mfhi = 1'b1; b_wen = 1'b1; b_dest = 5'd3; settle();
    chk("mfhi_data", {32'd0, rf_wdata}, 64'h1);
    chk("mfhi_dest", {59'd0, rf_wdest}, 64'd3);
    advance();
    clear_bus(); WB_valid = 1'b1; b_mflo = 1'b1; b_wen = 1'b1; b_dest = 5'd4; settle();
    chk("mflo_data", {32'd0, rf_wdata}, 64'hFFFF_FFFE);
    chk("mflo_dest", {59'd0, rf_wdest}, 64'd4);
    advance();

    // syscall at 0x40
    clear_bus(); WB_valid = 1'b1; b_sys = 1'b1; b_wen = 1'b1; b_dest = 5'd5; b_pc = 32'h40;
    settle();
    chk("sys_exc_bus", {31'd0, exc_bus}, 64'h1_0000_0000);
    chk("sys_cancel", {63'd0, cancel}, 64'd1);
    chk("sys_rf_wen", {63'd0, rf_wen}, 64'd0);
    advance();
    clear_bus(); settle(); chk("sys_pulse", {63'd0, cancel}, 64'd0); advance();
    rd_cp0({5'd14, 3'd0}); settle(); chk("sys_EPC", {32'd0, rf_wdata}, 64'h40); advance();
    rd_cp0({5'd13, 3'd0}); settle(); chk("sys_CAUSE", {32'd0, rf_wdata}, 64'h20); advance();
    rd_cp0({5'd12, 3'd0}); settle(); chk("sys_EXL", {63'd0, rf_wdata[1]}, 64'd1); advance();

    // mtc0 EPC then eret back-to-back
    clear_bus(); WB_valid = 1'b1; b_mtc0 = 1'b1; b_addr = {5'd14, 3'd0}; b_mem = 32'h1234;
    settle(); advance();
    clear_bus(); WB_valid = 1'b1; b_eret = 1'b1; settle();
    chk("eret_exc_bus", {31'd0, exc_bus}, 64'h1_0000_1234);
    advance();
    rd_cp0({5'd12, 3'd0}); settle(); chk("eret_EXL", {63'd0, rf_wdata[1]}, 64'd0); advance();

    // unimplemented CP0 read; CAUSE is not writable
    rd_cp0({5'd9, 3'd0}); b_mem = 32'hABCD_0000; settle();
    chk("unimpl_rdata", {32'd0, rf_wdata}, 64'd0);
    chk("unimpl_wen", {63'd0, rf_wen}, 64'd1);
    advance();
    clear_bus(); WB_valid = 1'b1; b_mtc0 = 1'b1; b_addr = {5'd13, 3'd0}; b_mem = 32'hFFFF_FFFF;
    settle(); advance();
    rd_cp0({5'd13, 3'd0}); settle(); chk("cause_ro", {32'd0, rf_wdata}, 64'h20); advance();

    // invalid slot carrying write and break requests
    clear_bus(); b_wen = 1'b1; b_hiw = 1'b1; b_brk = 1'b1; b_dest = 5'd9; b_mem = 32'hDEAD_BEEF;
    settle();
    chk("inv_rf_wen", {63'd0, rf_wen}, 64'd0);
    chk("inv_exc", {63'd0, exc_bus[32]}, 64'd0);
    chk("inv_wdest", {59'd0, WB_wdest}, 64'd0);
    advance();
    clear_bus(); settle(); chk("inv_HI", {32'd0, HI_data}, 64'h1); advance();

    // randomized instruction stream
    for (int i = 0; i < 3000; i++) begin
      int kind;
      clear_bus();
      kind     = $urandom_range(0, 11);
      rst      = ($urandom_range(0, 59) == 0);
      WB_valid = ($urandom_range(0, 3) != 0);
      b_wen    = $urandom_range(0, 1) == 1;
      b_dest   = 5'($urandom);
      b_mem    = $urandom;
      b_lo     = $urandom;
      b_pc     = {$urandom} & 32'hFFFF_FFFC;
      case ($urandom_range(0, 3))
        0: b_addr = {5'd12, 3'd0};
        1: b_addr = {5'd13, 3'd0};
        2: b_addr = {5'd14, 3'd0};
        default: b_addr = 8'($urandom);
      endcase
      case (kind)
        1: begin b_hiw = 1'b1; b_low = 1'b1; end
        2: b_hiw = 1'b1;
        3: b_low = 1'b1;
        4: b_mfhi = 1'b1;
        5: b_mflo = 1'b1;
        6: b_mtc0 = 1'b1;
        7: b_mfc0 = 1'b1;
        8: b_sys = 1'b1;
        9: b_brk = 1'b1;
        10: b_eret = 1'b1;
        default: ;
      endcase
      settle();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
